// File: rtl/entropy_oht_if.sv
// Bus between one entropy lane and its online health test block.
interface entropy_oht_if;
    logic bit_in;
    logic bit_valid;
    logic clear;
    logic bit_out;
    logic bit_out_valid;
    logic healthy;
    logic rct_fail;
    logic apt_fail;

    modport master (
        output bit_in, bit_valid, clear,
        input  bit_out, bit_out_valid, healthy, rct_fail, apt_fail
    );

    modport slave (
        input  bit_in, bit_valid, clear,
        output bit_out, bit_out_valid, healthy, rct_fail, apt_fail
    );
endinterface

// File: rtl/entropy_oht.sv
// Online health test for a raw entropy lane: repetition-count test (RCT)
// and adaptive-proportion test (APT). Bits pass through with one cycle of
// latency and are only marked valid while the source is judged healthy.
module entropy_oht #(
    parameter int RCT_CUTOFF = 32,
    parameter int APT_WINDOW = 512,
    parameter int APT_CUTOFF = 410
) (
    input  logic          clk,
    input  logic          rst_n,
    entropy_oht_if.slave  bus
);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int AW = $clog2(APT_WINDOW + 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(RCT_CUTOFF);
    localparam logic [AW-1:0] WIN_LEN   = AW'(APT_WINDOW);
    localparam logic [AW-1:0] MATCH_MAX = AW'(APT_CUTOFF);

    typedef enum logic [1:0] {WARMUP, HEALTHY, FAILED} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] run, run_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [AW-1:0] match, match_nxt;
    logic          last_bit, ref_bit;
    logic          rct_fail, apt_fail;
    logic          bit_out, bit_out_valid;
    logic          proc, win_start, rct_hit, apt_hit;

    // A same-cycle clear always wins over a valid sample.
    assign proc      = bus.bit_valid & ~bus.clear;
    // idx==0 only right after reset/clear; idx==WIN_LEN means the last window closed.
    assign win_start = (idx == '0) || (idx == WIN_LEN);

    // Next values of the run and window counters for a processed sample.
    always_comb begin
        run_nxt   = run;
        idx_nxt   = idx;
        match_nxt = match;
        rct_hit   = 1'b0;
        apt_hit   = 1'b0;
        if (proc) begin
            // run==0 marks "no previous sample", so the first bit starts a run of 1.
            if (run == '0 || bus.bit_in != last_bit)
                run_nxt = RW'(1);
            else if (run != RUN_MAX)
                run_nxt = run + RW'(1);

            if (win_start) begin
                idx_nxt   = AW'(1);
                match_nxt = AW'(1);
            end else begin
                idx_nxt = idx + AW'(1);
                if (bus.bit_in == ref_bit)
                    match_nxt = match + AW'(1);
            end

            rct_hit = (run_nxt == RUN_MAX);
            apt_hit = (match_nxt == MATCH_MAX);
        end
    end

    // Health state transitions; FAILED is left only through clear or reset.
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = WARMUP;
        end else if (proc) begin
            if (rct_hit || apt_hit)
                state_nxt = FAILED;
            else if (state == WARMUP && idx_nxt == WIN_LEN && !rct_fail && !apt_fail)
                state_nxt = HEALTHY;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WARMUP;
        else        state <= state_nxt;
    end

    // Counters, reference bits, sticky flags and the pass-through bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run           <= '0;
            idx           <= '0;
            match         <= '0;
            last_bit      <= 1'b0;
            ref_bit       <= 1'b0;
            rct_fail      <= 1'b0;
            apt_fail      <= 1'b0;
            bit_out       <= 1'b0;
            bit_out_valid <= 1'b0;
        end else if (bus.clear) begin
            run           <= '0;
            idx           <= '0;
            match         <= '0;
            last_bit      <= 1'b0;
            ref_bit       <= 1'b0;
            rct_fail      <= 1'b0;
            apt_fail      <= 1'b0;
            bit_out_valid <= 1'b0;
        end else if (proc) begin
            run      <= run_nxt;
            idx      <= idx_nxt;
            match    <= match_nxt;
            last_bit <= bus.bit_in;
            if (win_start) ref_bit <= bus.bit_in;
            rct_fail <= rct_fail | rct_hit;
            apt_fail <= apt_fail | apt_hit;
            bit_out  <= bus.bit_in;
            // Only samples taken entirely inside HEALTHY are trusted: the sample
            // that closes warmup and the sample that trips a test are both withheld.
            bit_out_valid <= (state == HEALTHY) && (state_nxt == HEALTHY);
        end else begin
            bit_out_valid <= 1'b0;
        end
    end

    assign bus.bit_out       = bit_out;
    assign bus.bit_out_valid = bit_out_valid;
    assign bus.healthy       = (state == HEALTHY);
    assign bus.rct_fail      = rct_fail;
    assign bus.apt_fail      = apt_fail;
endmodule

// File: tb/tb_entropy_oht.sv
// Testbench for entropy_oht: directed scenarios plus randomized traffic,
// all checked against a sample-history reference model.
module tb_entropy_oht;
    localparam int RCT  = 32;
    localparam int WIN  = 512;
    localparam int ACUT = 410;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    entropy_oht_if bus ();

    entropy_oht #(.RCT_CUTOFF(RCT), .APT_WINDOW(WIN), .APT_CUTOFF(ACUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model: keeps the raw recent history and the current window's samples.
    bit hist[$];
    bit win[$];
    bit m_out, m_vld, m_hl, m_rf, m_af;

    function automatic void m_reset(bit keep_out);
        hist.delete();
        win.delete();
        m_vld = 0; m_hl = 0; m_rf = 0; m_af = 0;
        if (!keep_out) m_out = 0;
    endfunction

    function automatic void m_sample(bit b);
        int run, mt;
        bit was_hl, hit;
        hist.push_back(b);
        if (hist.size() > RCT) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == b) run++;
            else break;
        end
        if (win.size() == WIN) win.delete();
        win.push_back(b);
        mt = 0;
        foreach (win[i]) if (win[i] == win[0]) mt++;
        was_hl = m_hl;
        hit = 0;
        if (run == RCT) begin m_rf = 1; hit = 1; end
        if (mt == ACUT) begin m_af = 1; hit = 1; end
        if (hit) m_hl = 0;
        else if (!m_rf && !m_af && !m_hl && win.size() == WIN) m_hl = 1;
        m_vld = was_hl && m_hl;
        m_out = b;
    endfunction

    function automatic logic [4:0] dut_v();
        return {bus.bit_out, bus.bit_out_valid, bus.healthy, bus.rct_fail, bus.apt_fail};
    endfunction

    function automatic logic [4:0] exp_v();
        return {m_out, m_vld, m_hl, m_rf, m_af};
    endfunction

    // Drive one cycle, advance the model, and leave time 1 unit after the edge.
    task automatic step(bit b, bit v, bit c);
        bus.bit_in = b; bus.bit_valid = v; bus.clear = c;
        @(posedge clk);
        if (c) m_reset(1);
        else if (v) m_sample(b);
        else m_vld = 0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.bit_in = 0; bus.bit_valid = 0; bus.clear = 0;
        m_reset(0);
        repeat (3) @(posedge clk);
        #1;
        if (dut_v() !== 5'b0) begin
            errors++; $display("FAIL reset: got %b want 00000", dut_v());
        end
        checks++;
        rst_n = 1;
    endtask

    task automatic test_warmup();
        for (int i = 0; i < WIN; i++) begin
            step(i[0], 1, 0);
            if (dut_v() !== exp_v()) begin
                errors++; $display("FAIL warmup[%0d]: got %b want %b", i, dut_v(), exp_v());
            end
            checks++;
        end
        if (bus.healthy !== 1'b1 || bus.bit_out_valid !== 1'b0) begin
            errors++; $display("FAIL warmup_end: healthy=%b vld=%b want 1 0", bus.healthy, bus.bit_out_valid);
        end
        checks++;
        step(0, 1, 0);
        if (bus.bit_out_valid !== 1'b1 || dut_v() !== exp_v()) begin
            errors++; $display("FAIL first_valid: got %b want %b", dut_v(), exp_v());
        end
        checks++;
    endtask

    task automatic test_rct();
        for (int i = 0; i < RCT; i++) begin
            step(1, 1, 0);
            if (dut_v() !== exp_v()) begin
                errors++; $display("FAIL rct[%0d]: got %b want %b", i, dut_v(), exp_v());
            end
            checks++;
        end
        if ({bus.bit_out_valid, bus.healthy, bus.rct_fail, bus.apt_fail} !== 4'b0010) begin
            errors++; $display("FAIL rct_end: vld/hl/rct/apt=%b want 0010",
                               {bus.bit_out_valid, bus.healthy, bus.rct_fail, bus.apt_fail});
        end
        checks++;
    endtask

    task automatic test_clear();
        step(1, 1, 1);
        if ({bus.bit_out_valid, bus.healthy, bus.rct_fail, bus.apt_fail} !== 4'b0000
            || dut_v() !== exp_v()) begin
            errors++; $display("FAIL clear: got %b want %b", dut_v(), exp_v());
        end
        checks++;
        for (int i = 0; i < WIN; i++) begin
            step(i[0], 1, 0);
            if (dut_v() !== exp_v()) begin
                errors++; $display("FAIL rewarm[%0d]: got %b want %b", i, dut_v(), exp_v());
            end
            checks++;
            if (i == WIN - 2 && bus.healthy !== 1'b0) begin
                errors++; $display("FAIL rewarm_early: healthy=%b want 0", bus.healthy);
            end
        end
        if (bus.healthy !== 1'b1) begin
            errors++; $display("FAIL rewarm_done: healthy=%b want 1", bus.healthy);
        end
        checks++;
    endtask

    task automatic test_apt();
        step(0, 0, 1);
        // 409 matches: non-matches every 5th sample plus the last one.
        for (int i = 0; i < WIN; i++) begin
            step((i % 5 == 4) || (i == WIN - 1), 1, 0);
            if (dut_v() !== exp_v()) begin
                errors++; $display("FAIL apt409[%0d]: got %b want %b", i, dut_v(), exp_v());
            end
            checks++;
        end
        if (bus.apt_fail !== 1'b0 || bus.healthy !== 1'b1) begin
            errors++; $display("FAIL apt409_end: apt=%b hl=%b want 0 1", bus.apt_fail, bus.healthy);
        end
        checks++;
        // 31-bit runs of the reference bit: the 410th match lands on sample 422.
        for (int i = 0; i < 430; i++) begin
            step(i % 32 == 31, 1, 0);
            if (dut_v() !== exp_v()) begin
                errors++; $display("FAIL apt410[%0d]: got %b want %b", i, dut_v(), exp_v());
            end
            checks++;
            if (i == 421 && bus.apt_fail !== 1'b0) begin
                errors++; $display("FAIL apt_early: apt=%b want 0", bus.apt_fail);
            end
            if (i == 422 && {bus.apt_fail, bus.rct_fail, bus.healthy, bus.bit_out_valid} !== 4'b1000) begin
                errors++; $display("FAIL apt_trip: apt/rct/hl/vld=%b want 1000",
                                   {bus.apt_fail, bus.rct_fail, bus.healthy, bus.bit_out_valid});
            end
        end
        checks += 2;
    endtask

    task automatic test_async_reset();
        step(0, 0, 1);
        for (int i = 0; i < WIN + 300; i++) step(i[0], 1, 0);
        if (bus.healthy !== 1'b1 || dut_v() !== exp_v()) begin
            errors++; $display("FAIL pre_areset: got %b want %b", dut_v(), exp_v());
        end
        checks++;
        #2 rst_n = 0;
        #1;
        if (dut_v() !== 5'b0) begin
            errors++; $display("FAIL async_reset: got %b want 00000", dut_v());
        end
        checks++;
        m_reset(0);
        bus.bit_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < WIN; i++) begin
            step(i[0], 1, 0);
            if (dut_v() !== exp_v()) begin
                errors++; $display("FAIL post_areset[%0d]: got %b want %b", i, dut_v(), exp_v());
            end
            checks++;
        end
        if (bus.healthy !== 1'b1) begin
            errors++; $display("FAIL post_areset_hl: healthy=%b want 1", bus.healthy);
        end
        checks++;
    endtask

    task automatic test_sparse();
        step(0, 0, 1);
        for (int s = 0; s <= WIN; s++) begin
            step(s[0], 1, 0);
            if (dut_v() !== exp_v()) begin
                errors++; $display("FAIL sparse[%0d]: got %b want %b", s, dut_v(), exp_v());
            end
            checks++;
            for (int g = 0; g < 2; g++) begin
                step(1'($urandom_range(0, 1)), 0, 0);
                if (dut_v() !== exp_v()) begin
                    errors++; $display("FAIL sparse_gap[%0d]: got %b want %b", s, dut_v(), exp_v());
                end
                checks++;
            end
            if (s == WIN - 1 && bus.healthy !== 1'b1) begin
                errors++; $display("FAIL sparse_hl: healthy=%b want 1", bus.healthy);
            end
        end
        checks++;
    endtask

    task automatic test_random();
        int bias;
        step(0, 0, 1);
        bias = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 256 == 0) bias = $urandom_range(50, 97);
            step($urandom_range(0, 99) < bias, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 599) == 0);
            if (dut_v() !== exp_v()) begin
                errors++; $display("FAIL random[%0d]: got %b want %b", i, dut_v(), exp_v());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_rct();
        test_clear();
        test_apt();
        test_async_reset();
        test_sparse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/entropy_oht.md
ENTROPY_OHT -- requirements
Module: entropy_oht

Interface
REQ-001 SHALL have parameter RCT_CUTOFF, default 32, meaning the run length of identical bits that flags a repetition-count failure.
REQ-002 SHALL have parameter APT_WINDOW, default 512, meaning the number of samples per adaptive-proportion window.
REQ-003 SHALL have parameter APT_CUTOFF, default 410, meaning the count of first-bit matches within one window that flags an adaptive-proportion failure.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port bit_in, input, 1 bit: raw entropy bit from one lane of the entropy/OHT mux.
REQ-007 SHALL have port bit_valid, input, 1 bit: bit_in is sampled on this cycle.
REQ-008 SHALL have port clear, input, 1 bit: synchronous restart of all test state.
REQ-009 SHALL have port bit_out, output, 1 bit: registered copy of the sampled bit.
REQ-010 SHALL have port bit_out_valid, output, 1 bit: bit_out is qualified and healthy.
REQ-011 SHALL have port healthy, output, 1 bit: state == HEALTHY.
REQ-012 SHALL have port rct_fail, output, 1 bit: sticky repetition-count failure flag.
REQ-013 SHALL have port apt_fail, output, 1 bit: sticky adaptive-proportion failure flag.

Function
REQ-014 SHALL implement states WARMUP, HEALTHY and FAILED, with WARMUP as the reset state.
REQ-015 SHALL process a sample only on cycles where bit_valid=1 and clear=0; other cycles hold all counters.
REQ-016 RCT: on the first sample after reset or clear, SHALL set last_bit=bit_in and run=1; thereafter bit_in==last_bit gives run+1, saturating at RCT_CUTOFF, otherwise run=1, and last_bit=bit_in.
REQ-017 SHALL set rct_fail on the clock edge where the updated run reaches RCT_CUTOFF.
REQ-018 APT: the first sample of a window SHALL load ref_bit=bit_in, match=1 and idx=1; each later sample SHALL increment idx and, if bit_in==ref_bit, increment match.
REQ-019 SHALL set apt_fail on the edge where the updated match reaches APT_CUTOFF; the window SHALL end when idx reaches APT_WINDOW, and the next sample SHALL start a new window.
REQ-020 SHALL size counters at $clog2(APT_WINDOW+1) bits and $clog2(RCT_CUTOFF+1) bits; counters SHALL never wrap.
REQ-021 WARMUP->HEALTHY SHALL occur on the edge that completes the first full window with neither fail flag set.
REQ-022 Any state SHALL go to FAILED on the edge where rct_fail or apt_fail is set; FAILED is exited only by clear or reset.
REQ-023 If both fails trigger on the same edge, SHALL set both flags.
REQ-024 SHALL register bit_out=bit_in on every processed sample, giving 1-cycle latency; bit_out otherwise holds.
REQ-025 SHALL set bit_out_valid=1 for one cycle after a processed sample only if the state after that edge is HEALTHY; the sample that causes a failure SHALL NOT be marked valid.
REQ-026 clear=1 SHALL, on the next edge, return to WARMUP, zero all counters and flags, and deassert bit_out_valid; a bit_valid in the same cycle SHALL be dropped.
REQ-027 When bit_valid is held continuously high, SHALL accept one sample per cycle with no back-pressure.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=WARMUP; run, match, idx=0; last_bit, ref_bit=0; bit_out=0; bit_out_valid=0; healthy=0; rct_fail=0; apt_fail=0.
REQ-029 Deassertion of rst_n SHALL be synchronous to clk; the first sample SHALL be taken on the first edge with rst_n=1 and bit_valid=1.
REQ-030 Reset asserted mid-window SHALL discard the partial window; no flag may survive reset.

Verification
REQ-031 Alternating 0/1 for 512 valid cycles -> healthy=1 after the 512th sample; bit_out_valid first asserts on the 513th sample.
REQ-032 After HEALTHY, 32 consecutive 1s -> rct_fail=1, state=FAILED, healthy=0 at the 32nd sample; that sample is not valid; apt_fail=0.
REQ-033 Window with 409 matches -> no fail; window with 410 matches (31-bit runs, no RCT) -> apt_fail=1 on the 410th match.
REQ-034 In FAILED, pulse clear with bit_valid=1 -> sample dropped, all flags=0, WARMUP, and a new 512-sample warmup is required.
REQ-035 Assert rst_n=0 asynchronously at idx=300 -> outputs clear with no clk edge; after release the window restarts at idx=1.
REQ-036 bit_valid toggling 1-of-3 cycles -> counters advance only on valid cycles; results match REQ-031 counted in samples.
